seq_div16: RTL and testbench
============================

SEQ_DIV16 -- requirements
Module: seq_div16

Interface
REQ-001 SHALL have parameter ITERS, default 16, the number of quotient bits resolved (one per cycle); only 16 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port dividend  input  16  numerator, captured with start.
REQ-007 SHALL have port divisor  input  16  denominator, captured with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted through the FIX cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port quotient  output  16  result quotient, held until the next accepted start.
REQ-011 SHALL have port remainder  output  16  result remainder, held likewise.
REQ-012 SHALL have ports N, Z, V, div_by_zero  output  1 each  quotient negative, quotient zero, saturation occurred, divisor was zero.

Function
REQ-013 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
- IDLE->PREP on start.
- PREP->ITER always.
- ITER->FIX after exactly ITERS cycles.
- FIX->DONE always.
- DONE->IDLE always.
REQ-014 SHALL, in PREP, latch the operand magnitudes (absolute values when is_signed) and the result signs: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
REQ-015 SHALL, in each ITER cycle, perform one restoring step: shift the {remainder, quotient} register left 1, trial-subtract the divisor magnitude over 17 bits, keep the difference and set quotient LSB = 1 iff the difference is non-negative.
REQ-016 SHALL use a 5-bit iteration counter that starts at 0 in PREP and leaves ITER when it reaches ITERS-1; it never wraps.
REQ-017 SHALL, in FIX, negate the magnitudes per REQ-014, giving truncating division; the remainder takes the dividend's sign or is zero.
REQ-018 SHALL saturate in signed mode when the quotient is out of range: 0x8000 / 0xFFFF gives quotient 0x7FFF, remainder 0x0000, V=1.
REQ-019 SHALL, when divisor == 0, set div_by_zero=1 and V=1, set remainder = dividend, and set quotient as follows:
- unsigned: 0xFFFF.
- signed, dividend >= 0: 0x7FFF.
- signed, dividend < 0: 0x8000.
REQ-020 SHALL keep the same fixed latency in all cases: done is high exactly 19 cycles after the edge at which start was sampled, counted as 1 PREP + 16 ITER + 1 FIX + 1 DONE cycles.
REQ-021 SHALL update quotient, remainder, N, Z, V and div_by_zero only on the FIX->DONE edge, and hold them stable otherwise.
REQ-022 SHALL derive N from quotient[15] and Z from quotient == 0 after saturation; N=0 in unsigned mode.
REQ-023 SHALL ignore start while busy or in DONE; a start asserted in the DONE cycle is not accepted.
REQ-024 SHALL accept a start in the first IDLE cycle after DONE (back-to-back period 20 cycles).

Reset
REQ-025 SHALL, on rst asserted (asynchronously, regardless of state), enter IDLE and clear busy, done, quotient, remainder, N, V, div_by_zero and the counter to 0; Z resets to 1.
REQ-026 SHALL abandon any in-flight division on reset mid-operation, produce no done pulse, and accept start on the first edge after rst deasserts.

Structure
REQ-027 SHALL take the state encoding, ITERS, and the constants SAT_MAX=0x7FFF, SAT_MIN=0x8000, UMAX=0xFFFF from shared package div_pkg.
REQ-028 SHALL place the 17-bit trial subtractor (difference and borrow) in one sub-module, div_trial_sub, instantiated once.

Verification
REQ-029 SHALL cover: unsigned 100 / 7 -> quotient 14, remainder 2, N=0 Z=0 V=0, done at cycle 19.
REQ-030 SHALL cover: signed -7 (0xFFF9) / 2 -> quotient 0xFFFD (-3), remainder 0xFFFF (-1), N=1.
REQ-031 SHALL cover: signed 0x8000 / 0xFFFF -> quotient 0x7FFF, remainder 0, V=1; and unsigned 0x8000 / 0xFFFF -> quotient 0, remainder 0x8000, Z=1.
REQ-032 SHALL cover: divisor 0 with signed dividend 0xFFF0 -> quotient 0x8000, remainder 0xFFF0, div_by_zero=1, V=1, same 19-cycle latency.
REQ-033 SHALL cover: start pulsed at ITER cycle 5 -> ignored with results unchanged; rst pulsed at ITER cycle 8 -> outputs at reset values, no done, and a new start is accepted next edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential 16-bit divider.
package div_pkg;

  localparam int unsigned ITERS = 16;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;
  localparam logic [15:0] UMAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } div_state_e;

  // Two's-complement negate when neg is set, pass through otherwise.
  function automatic logic [15:0] neg_if(input logic [15:0] v, input logic neg);
    return neg ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step: diff = a - b, borrow when a < b.
module div_trial_sub #(
  parameter int unsigned WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Extend by one bit so the top bit of the result is the borrow out.
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/seq_div16.sv
// Sequential 16-bit restoring divider, signed or unsigned, one quotient bit per cycle.
// Fixed latency: PREP, ITERS x ITER, FIX, DONE regardless of operands.
module seq_div16
  import div_pkg::*;
#(
  parameter int unsigned ITERS = div_pkg::ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        N,
  output logic        Z,
  output logic        V,
  output logic        div_by_zero
);

  localparam logic [4:0] LastIter = 5'(ITERS - 1);

  div_state_e state_q, state_d;

  // Raw operands captured with start.
  logic        sgn_q;
  logic [15:0] dvd_q, dvs_q;

  // Working registers.
  logic [15:0] bmag_q;
  logic        qneg_q, rneg_q;
  logic [15:0] rem_q, quo_q;
  logic [4:0]  cnt_q;

  // Result registers.
  logic [15:0] quo_res_q, rem_res_q;
  logic        n_q, z_q, v_q, dbz_q;

  // Operand magnitudes for PREP.
  logic        dvd_neg, dvs_neg;
  logic [15:0] amag, bmag;

  // Restoring step.
  logic [16:0] trial_diff;
  logic        trial_borrow;
  logic [15:0] rem_step, quo_step;
  logic        unused_diff_msb;

  // FIX-stage results.
  logic [15:0] fix_q, fix_r;
  logic        fix_v, fix_dbz, fix_n, fix_z;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StPrep:  state_d = StIter;
      StIter:  if (cnt_q == LastIter) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StPrep, StIter, StFix: busy = 1'b1;
      StDone:                done = 1'b1;
      default:               ;
    endcase
  end

  // Magnitudes and signs derived from the captured operands.
  always_comb begin
    dvd_neg = sgn_q & dvd_q[15];
    dvs_neg = sgn_q & dvs_q[15];
    amag    = neg_if(dvd_q, dvd_neg);
    bmag    = neg_if(dvs_q, dvs_neg);
  end

  div_trial_sub #(
    .WIDTH(17)
  ) u_trial (
    .a      ({rem_q, quo_q[15]}),
    .b      ({1'b0, bmag_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Restore on borrow; the kept difference is always below the divisor so fits 16 bits.
  always_comb begin
    unused_diff_msb = trial_diff[16];
    rem_step        = trial_borrow ? {rem_q[14:0], quo_q[15]} : trial_diff[15:0];
    quo_step        = {quo_q[14:0], ~trial_borrow};
  end

  // Operand capture on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_q <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
    end else if (state_q == StIdle && start) begin
      sgn_q <= is_signed;
      dvd_q <= dividend;
      dvs_q <= divisor;
    end
  end

  // Iteration datapath: PREP loads magnitudes, ITER shifts and subtracts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bmag_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == StPrep) begin
      bmag_q <= bmag;
      qneg_q <= dvd_neg ^ dvs_neg;
      rneg_q <= dvd_neg;
      rem_q  <= '0;
      quo_q  <= amag;
      cnt_q  <= '0;
    end else if (state_q == StIter) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      // Hold at the final count rather than wrapping.
      if (cnt_q != LastIter) cnt_q <= cnt_q + 5'd1;
    end
  end

  // Sign fix-up, saturation and divide-by-zero overrides.
  always_comb begin
    fix_q   = neg_if(quo_q, qneg_q);
    fix_r   = neg_if(rem_q, rneg_q);
    fix_v   = 1'b0;
    fix_dbz = 1'b0;
    if (dvs_q == 16'h0000) begin
      fix_dbz = 1'b1;
      fix_v   = 1'b1;
      fix_r   = dvd_q;
      if (!sgn_q)        fix_q = UMAX;
      else if (dvd_q[15]) fix_q = SAT_MIN;
      else                fix_q = SAT_MAX;
    end else if (sgn_q && !qneg_q && quo_q[15]) begin
      // Only the most-negative / -1 case lands here.
      fix_q = SAT_MAX;
      fix_v = 1'b1;
    end
    fix_n = sgn_q & fix_q[15];
    fix_z = (fix_q == 16'h0000);
  end

  // Results change only on the FIX->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_res_q <= '0;
      rem_res_q <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      v_q       <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (state_q == StFix) begin
      quo_res_q <= fix_q;
      rem_res_q <= fix_r;
      n_q       <= fix_n;
      z_q       <= fix_z;
      v_q       <= fix_v;
      dbz_q     <= fix_dbz;
    end
  end

  assign quotient    = quo_res_q;
  assign remainder   = rem_res_q;
  assign N           = n_q;
  assign Z           = z_q;
  assign V           = v_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: stimulus pushes expected results, a monitor checks on done.
module tb_seq_div16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done;
  logic [15:0] quotient, remainder;
  logic        N, Z, V, div_by_zero;

  always #5 clk = ~clk;

  seq_div16 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .N           (N),
    .Z           (Z),
    .V           (V),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic        sg;
    logic [15:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk("done_single_cycle", {31'b0, done_prev}, 32'd0);
      chk("done_expected", {31'b0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("latency", cyc, e.acc + 18);
        chk("quotient", {16'b0, quotient}, {16'b0, e.q});
        chk("remainder", {16'b0, remainder}, {16'b0, e.r});
        chk("flags_NZV_dbz", {28'b0, N, Z, V, div_by_zero}, {28'b0, e.n, e.z, e.v, e.dbz});
      end
    end
    done_prev <= done;
  end

  task automatic drive_start(input logic sg, input logic [15:0] dd, input logic [15:0] dv);
    is_signed = sg;
    dividend  = dd;
    divisor   = dv;
    start     = 1'b1;
  endtask

  // Call at a negedge just before the accepting edge.
  task automatic push_exp(input vec_t v);
    exp_t e;
    e.q   = v.q;
    e.r   = v.r;
    e.n   = v.n;
    e.z   = v.z;
    e.v   = v.v;
    e.dbz = v.dbz;
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  // Drop start after acceptance, wait for done, then step into the IDLE cycle.
  task automatic finish_op();
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wait_done();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy_done"}, {30'b0, busy, done}, 32'd0);
    chk({tag, "_quotient"}, {16'b0, quotient}, 32'd0);
    chk({tag, "_remainder"}, {16'b0, remainder}, 32'd0);
    chk({tag, "_NZV_dbz"}, {28'b0, N, Z, V, div_by_zero}, 32'b0100);
  endtask

  initial begin
    //          sg    dividend  divisor   quot      rem       n     z     v     dbz
    vecs[0]  = '{1'b0, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'hFFF0, 16'h0000, 16'h8000, 16'hFFF0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0005, 16'h0000, 16'h7FFF, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 16'h0000, 16'hFFFB, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Directed vectors issued back-to-back (start in the first IDLE cycle after DONE).
    for (int i = 0; i < 13; i++) begin
      drive_start(vecs[i].sg, vecs[i].dd, vecs[i].dv);
      push_exp(vecs[i]);
      finish_op();
    end

    // Start held in the DONE cycle must not be accepted.
    drive_start(vecs[0].sg, vecs[0].dd, vecs[0].dv);
    push_exp(vecs[0]);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    drive_start(1'b0, 16'd50, 16'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("done_start_ignored", {31'b0, busy}, 32'd0);

    // Start pulsed in ITER cycle 5 is ignored; previous results held meanwhile.
    drive_start(vecs[1].sg, vecs[1].dd, vecs[1].dv);
    push_exp(vecs[1]);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    drive_start(1'b0, 16'h1234, 16'h0003);
    chk("hold_quotient", {16'b0, quotient}, {16'b0, vecs[0].q});
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset in ITER cycle 8 abandons the operation; start accepted on the next edge.
    drive_start(vecs[0].sg, vecs[0].dd, vecs[0].dv);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b0;
    drive_start(vecs[3].sg, vecs[3].dd, vecs[3].dv);
    push_exp(vecs[3]);
    finish_op();

    repeat (25) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
    $fatal(1);
  end

endmodule
